// File: rtl/imm_encoder.sv
// Iterative immediate encoder: finds the Instr[23:0] field and ImmSrc code that
// the immediate extender turns back into the requested 32-bit value.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Value,
    input  logic [1:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Ok,
    output logic [1:0]  ImmSrcOut,
    output logic [23:0] Field
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] TRY_8  = 2'b00;
    localparam logic [1:0] TRY_12 = 2'b01;
    localparam logic [1:0] TRY_24 = 2'b10;
    localparam logic [1:0] AUTO   = 2'b11;

    state_t      state_q;
    logic [1:0]  try_q;
    logic        auto_q;
    logic [31:0] value_q;
    logic [2:0]  fit_q;
    logic        armed_q;
    logic        out_valid_q;
    logic        ok_q;
    logic [1:0]  src_q;
    logic [23:0] field_q;

    logic [2:0]  fit_d;
    logic        try_fit;
    logic [23:0] field_d;

    // Fit of every format, registered in the first CHECK cycle; later cycles
    // only select one entry so each try costs exactly one cycle.
    always_comb begin
        fit_d[0] = (value_q[31:8] == 24'h0);
        fit_d[1] = (value_q[31:12] == 20'h0);
        fit_d[2] = (value_q[1:0] == 2'b00) && (value_q[31:26] == {6{value_q[25]}});
    end

    always_comb begin
        try_fit = 1'b0;
        field_d = 24'h0;
        case (try_q)
            TRY_8: begin
                try_fit = fit_q[0];
                field_d = {16'h0, value_q[7:0]};
            end
            TRY_12: begin
                try_fit = fit_q[1];
                field_d = {12'h0, value_q[11:0]};
            end
            default: begin
                try_fit = fit_q[2];
                field_d = value_q[25:2];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            try_q       <= TRY_8;
            auto_q      <= 1'b0;
            value_q     <= 32'h0;
            fit_q       <= 3'b000;
            armed_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ok_q        <= 1'b0;
            src_q       <= 2'b00;
            field_q     <= 24'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        value_q <= Value;
                        auto_q  <= (ImmSrc == AUTO);
                        try_q   <= (ImmSrc == AUTO) ? TRY_8 : ImmSrc;
                        armed_q <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!armed_q) begin
                        fit_q   <= fit_d;
                        armed_q <= 1'b1;
                    end else if (try_fit) begin
                        ok_q        <= 1'b1;
                        field_q     <= field_d;
                        src_q       <= try_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (auto_q && (try_q != TRY_24)) begin
                        try_q <= try_q + 2'd1;
                    end else begin
                        ok_q        <= 1'b0;
                        field_q     <= 24'h0;
                        src_q       <= try_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Ok        = ok_q;
    assign ImmSrcOut = src_q;
    assign Field     = field_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomised round-trip checks for imm_encoder.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Value;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic        Ok;
    logic [1:0]  ImmSrcOut;
    logic [23:0] Field;

    int total = 0;
    int bad   = 0;

    imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Value     (Value),
        .ImmSrc    (ImmSrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Ok        (Ok),
        .ImmSrcOut (ImmSrcOut),
        .Field     (Field)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [23:0] f, input logic [1:0] src);
        case (src)
            2'b00:   extend = {24'h0, f[7:0]};
            2'b01:   extend = {20'h0, f[11:0]};
            2'b10:   extend = {{6{f[23]}}, f, 2'b00};
            default: extend = 32'hxxxx_xxxx;
        endcase
    endfunction

    // Waits for out_valid after the accept edge; lat = edges after accept.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL timeout: out_valid never rose within %0d cycles", lat);
        end
    endtask

    task automatic send(input logic [31:0] v, input logic [1:0] m);
        @(negedge clk);
        Value    = v;
        ImmSrc   = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] v;
        logic [1:0]  m;
        logic        ok;
        logic [23:0] f;
        logic [1:0]  src;
        int          lat;
    } vec_t;

    vec_t vecs[10] = '{
        '{32'h0000_00A5, 2'b00, 1'b1, 24'h0000A5, 2'b00, 2},
        '{32'h0000_0100, 2'b00, 1'b0, 24'h000000, 2'b00, 2},
        '{32'h0000_0FFF, 2'b01, 1'b1, 24'h000FFF, 2'b01, 2},
        '{32'hFFFF_FFF8, 2'b10, 1'b1, 24'hFFFFFE, 2'b10, 2},
        '{32'h0200_0000, 2'b10, 1'b0, 24'h000000, 2'b10, 2},
        '{32'h0000_0006, 2'b10, 1'b0, 24'h000000, 2'b10, 2},
        '{32'h0000_0345, 2'b11, 1'b1, 24'h000345, 2'b01, 3},
        '{32'h0040_0000, 2'b11, 1'b1, 24'h100000, 2'b10, 4},
        '{32'h0040_0001, 2'b11, 1'b0, 24'h000000, 2'b10, 4},
        '{32'h0000_00A5, 2'b11, 1'b1, 24'h0000A5, 2'b00, 2}
    };

    initial begin
        int          lat;
        logic [31:0] v;
        logic [1:0]  m;
        logic [2:0]  fits;
        logic        exp_ok;
        logic        seen;
        logic [23:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Value     = 32'h0;
        ImmSrc    = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ok",        {31'h0, Ok},        32'h0);
        chk("rst_field",     {8'h0, Field},      32'h0);
        chk("rst_src",       {30'h0, ImmSrcOut}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready},  32'h1);

        foreach (vecs[i]) begin
            send(vecs[i].v, vecs[i].m);
            wait_result(lat);
            chk($sformatf("v%0d_lat", i),   lat,                    vecs[i].lat);
            chk($sformatf("v%0d_ok", i),    {31'h0, Ok},            {31'h0, vecs[i].ok});
            chk($sformatf("v%0d_field", i), {8'h0, Field},          {8'h0, vecs[i].f});
            chk($sformatf("v%0d_src", i),   {30'h0, ImmSrcOut},     {30'h0, vecs[i].src});
            chk($sformatf("v%0d_busy", i),  {31'h0, in_ready},      32'h0);
            take();
            chk($sformatf("v%0d_idle", i),  {31'h0, in_ready},      32'h1);
            chk($sformatf("v%0d_drop", i),  {31'h0, out_valid},     32'h0);
        end

        // Backpressure with a competing request held on the inputs.
        send(32'h0000_0012, 2'b00);
        wait_result(lat);
        held = Field;
        chk("bp_field0", {8'h0, held}, 32'h12);
        @(negedge clk);
        Value    = 32'h0000_0034;
        ImmSrc   = 2'b00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid",    {31'h0, out_valid}, 32'h1);
            chk("bp_field",    {8'h0, Field},      32'h12);
            chk("bp_in_ready", {31'h0, in_ready},  32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_valid", {31'h0, out_valid}, 32'h0);
        chk("bp_hs_ready", {31'h0, in_ready},  32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", {31'h0, in_ready}, 32'h0);
        wait_result(lat);
        chk("bp_lat2",   lat,           2);
        chk("bp_field2", {8'h0, Field}, 32'h34);
        take();

        // Reset during the second CHECK cycle of an auto request.
        send(32'h0040_0000, 2'b11);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_valid",    {31'h0, out_valid}, 32'h0);
        chk("mr_ok",       {31'h0, Ok},        32'h0);
        chk("mr_field",    {8'h0, Field},      32'h0);
        chk("mr_src",      {30'h0, ImmSrcOut}, 32'h0);
        chk("mr_in_ready", {31'h0, in_ready},  32'h1);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mr_no_result", {31'h0, seen},     32'h0);
        chk("mr_idle",      {31'h0, in_ready}, 32'h1);

        // Random round-trip against the extender model.
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom & 32'h0000_00FF;
                1: v = $urandom & 32'h0000_0FFF;
                2: begin
                    v = $urandom & 32'h03FF_FFFC;
                    v[31:26] = {6{v[25]}};
                end
                default: v = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) v[0] = 1'b1;
            m = 2'($urandom_range(0, 3));
            fits[0] = (v < 32'd256);
            fits[1] = (v < 32'd4096);
            fits[2] = (v[1:0] == 2'b00) &&
                      ($signed(v) >= -32'sd33554432) && ($signed(v) < 32'sd33554432);
            exp_ok = (m == 2'b11) ? |fits : fits[m];
            send(v, m);
            wait_result(lat);
            chk("rnd_ok", {31'h0, Ok}, {31'h0, exp_ok});
            if (Ok) chk("rnd_trip", extend(Field, ImmSrcOut), v);
            take();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
